// File: rtl/ed25519_mul_modp_arb_pkg.sv
// Shared types and constants for the ed25519 field-multiplier arbiter and its bench.
// Default configuration, metadata layout and the field prime.
package ed25519_mul_modp_arb_pkg;

   localparam int unsigned FeW       = 255;
   localparam int unsigned ArbNReq   = 4;
   localparam int unsigned ArbTagW   = 8;
   localparam int unsigned ArbMulLat = 12;
   localparam int unsigned ArbMaxOut = 16;
   localparam int unsigned ArbIdW    = $clog2(ArbNReq);
   localparam int unsigned ArbMetaW  = 1 + ArbIdW + ArbTagW;

   // Metadata lane layout for the default configuration: {vld, id, tag}.
   typedef struct packed {
      logic               vld;
      logic [ArbIdW-1:0]  id;
      logic [ArbTagW-1:0] tag;
   } mul_meta_t;

   typedef enum logic [0:0] {StFlush, StRun} arb_state_e;

   localparam logic [FeW-1:0] ED25519_P =
      255'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;

endpackage

// File: rtl/ed25519_mul_modp_arb_rr_arbiter.sv
// Round-robin priority pick: first asserted request at or after ptr_i, wrapping N-1 -> 0.
// Returns a one-hot grant and its index.
module ed25519_mul_modp_arb_rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req_i,
   input  logic [IdxW-1:0] ptr_i,
   output logic [N-1:0]    gnt_o,
   output logic [IdxW-1:0] idx_o,
   output logic            any_o
);

   logic [IdxW-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = '0;
      for (int unsigned off = 0; off < N; off++) begin
         cand = IdxW'((32'(ptr_i) + off) % N);
         if (!any_o && req_i[cand]) begin
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
            any_o       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ed25519_mul_modp_arb.sv
// Shares one fixed-latency field multiplier between N_REQ requesters with round-robin grant,
// per-requester credits and id/tag routing of results through the multiplier metadata lane.
module ed25519_mul_modp_arb
   import ed25519_mul_modp_arb_pkg::*;
#(
   parameter int unsigned N_REQ   = ArbNReq,
   parameter int unsigned TAG_W   = ArbTagW,
   parameter int unsigned MUL_LAT = ArbMulLat,
   parameter int unsigned MAX_OUT = ArbMaxOut,
   localparam int unsigned ID_W   = $clog2(N_REQ),
   localparam int unsigned META_W = 1 + ID_W + TAG_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*FeW-1:0]   req_a,
   input  logic [N_REQ*FeW-1:0]   req_b,
   input  logic [N_REQ*TAG_W-1:0] req_tag,
   output logic [FeW-1:0]         mul_in0,
   output logic [FeW-1:0]         mul_in1,
   output logic [META_W-1:0]      mul_m_i,
   input  logic [META_W-1:0]      mul_m_o,
   input  logic [FeW-1:0]         mul_out0,
   output logic                   res_valid,
   output logic [ID_W-1:0]        res_id,
   output logic [TAG_W-1:0]       res_tag,
   output logic [FeW-1:0]         res_data,
   output logic                   idle,
   output logic                   err
);

   localparam int unsigned CntW   = $clog2(MAX_OUT + 1);
   localparam int unsigned FlushW = $clog2(MUL_LAT + 1);

   typedef struct packed {
      logic             vld;
      logic [ID_W-1:0]  id;
      logic [TAG_W-1:0] tag;
   } meta_t;

   arb_state_e                   state_q, state_d;
   logic [FlushW-1:0]            flush_cnt_q, flush_cnt_d;
   logic                         flush_done, flush_done_d;
   logic [N_REQ-1:0][CntW-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic                         err_q, err_d;
   logic                         idle_q, idle_d;

   logic [N_REQ-1:0]             eligible, gnt, ret_hit;
   logic [ID_W-1:0]              gnt_idx;
   logic                         accept;
   logic [FeW-1:0]               sel_a, sel_b;
   logic [TAG_W-1:0]             sel_tag;

   logic [FeW-1:0]               in0_q, in1_q;
   meta_t                        meta_q, ret_meta;
   logic                         ret_vld;
   logic                         res_valid_q;
   logic [ID_W-1:0]              res_id_q;
   logic [TAG_W-1:0]             res_tag_q;
   logic [FeW-1:0]               res_data_q;

   // Flush FSM: the multiplier metadata lane is not reset, so stale valids must drain first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFlush;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      unique case (state_q)
         StFlush: begin
            if (flush_cnt_q == FlushW'(MUL_LAT)) state_d = StRun;
            else flush_cnt_d = flush_cnt_q + FlushW'(1);
         end
         StRun: ;
      endcase
   end

   always_comb begin
      flush_done   = (state_q == StRun);
      flush_done_d = (state_d == StRun);
   end

   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         eligible[i] = req_valid[i] && (cnt_q[i] < CntW'(MAX_OUT)) && flush_done;
      end
   end

   ed25519_mul_modp_arb_rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .req_i (eligible),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (accept)
   );

   assign req_ready = gnt;

   always_comb begin
      sel_a   = '0;
      sel_b   = '0;
      sel_tag = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (gnt[i]) begin
            sel_a   = req_a[i*FeW +: FeW];
            sel_b   = req_b[i*FeW +: FeW];
            sel_tag = req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
   end

   assign ret_meta = mul_m_o;
   assign ret_vld  = ret_meta.vld && flush_done;

   always_comb begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
         ret_hit[i] = ret_vld && (ret_meta.id == ID_W'(i));
      end
   end

   // Simultaneous accept and return leave a counter unchanged; a stray return never underflows.
   always_comb begin
      cnt_d  = cnt_q;
      err_d  = err_q;
      idle_d = flush_done_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (ret_hit[i] && cnt_q[i] == '0) err_d = 1'b1;
         if (gnt[i] && !ret_hit[i]) begin
            cnt_d[i] = cnt_q[i] + CntW'(1);
         end else if (!gnt[i] && ret_hit[i] && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CntW'(1);
         end
         if (cnt_d[i] != '0) idle_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
         idle_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
         idle_q   <= idle_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in0_q  <= '0;
         in1_q  <= '0;
         meta_q <= '0;
      end else begin
         meta_q.vld <= accept;
         if (accept) begin
            in0_q      <= sel_a;
            in1_q      <= sel_b;
            meta_q.id  <= gnt_idx;
            meta_q.tag <= sel_tag;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_tag_q   <= '0;
         res_data_q  <= '0;
      end else begin
         res_valid_q <= ret_vld;
         if (ret_vld) begin
            res_id_q   <= ret_meta.id;
            res_tag_q  <= ret_meta.tag;
            res_data_q <= mul_out0;
         end
      end
   end

   assign mul_in0   = in0_q;
   assign mul_in1   = in1_q;
   assign mul_m_i   = meta_q;
   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_tag   = res_tag_q;
   assign res_data  = res_data_q;
   assign idle      = idle_q;
   assign err       = err_q;

endmodule
